// File: rtl/gemm_operand_fetcher.sv
// gemm_operand_fetcher: fetches one A tile and one B tile per GEMM step.
// Issues one read per TCDM port (NumPorts for A, NumPorts for B), collects
// the responses into a buffer and hands the two tiles to the GEMM array via
// a valid/ready handshake.
// Optional feature macro: GEMM_FETCH_PERF_EN adds stall/fetch counters.
module gemm_operand_fetcher #(
  parameter int NumPorts  = 8,
  parameter int DataWidth = 64,
  parameter int AddrWidth = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              start_valid_i,
  output logic                              start_ready_o,
  input  logic [AddrWidth-1:0]              addr_a_i,
  input  logic [AddrWidth-1:0]              addr_b_i,
  output logic [2*NumPorts-1:0]             tcdm_req_o,
  output logic [2*NumPorts*AddrWidth-1:0]   tcdm_addr_o,
  input  logic [2*NumPorts-1:0]             tcdm_gnt_i,
  input  logic [2*NumPorts-1:0]             tcdm_rvalid_i,
  input  logic [2*NumPorts*DataWidth-1:0]   tcdm_rdata_i,
  output logic                              data_valid_o,
  input  logic                              data_ready_i,
  output logic [NumPorts*DataWidth-1:0]     data_a_o,
  output logic [NumPorts*DataWidth-1:0]     data_b_o,
  output logic                              busy_o
`ifdef GEMM_FETCH_PERF_EN
  ,
  input  logic                              perf_clr_i,
  output logic [31:0]                       perf_stall_o,
  output logic [31:0]                       perf_fetch_o
`endif
);

  localparam int NumAll = 2 * NumPorts;
  localparam logic [AddrWidth-1:0] WordBytes = AddrWidth'(DataWidth / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    OUT   = 2'd2
  } state_e;

  state_e                          state_q;
  logic [NumAll-1:0]               req_q;
  logic [NumAll-1:0]               gnt_done_q;
  logic [NumAll-1:0]               data_done_q;
  logic [NumAll*AddrWidth-1:0]     addr_q;
  logic [NumAll*DataWidth-1:0]     buf_q;
  logic                            valid_q;
  logic                            ready_q;
  logic                            busy_q;

  logic [NumAll*AddrWidth-1:0]     addr_d;
  logic [NumAll-1:0]               grant_s;
  logic [NumAll-1:0]               capture_s;
  logic [NumAll-1:0]               done_d;

  // Per-port addresses derived from the incoming bases; wrap modulo 2^AddrWidth.
  always_comb begin
    addr_d = '0;
    for (int p = 0; p < NumPorts; p++) begin
      addr_d[p*AddrWidth +: AddrWidth]            = addr_a_i + AddrWidth'(p) * WordBytes;
      addr_d[(p+NumPorts)*AddrWidth +: AddrWidth] = addr_b_i + AddrWidth'(p) * WordBytes;
    end
  end

  // Grant and response qualification; a response counts only for an outstanding read.
  always_comb begin
    grant_s   = req_q & tcdm_gnt_i;
    capture_s = tcdm_rvalid_i & gnt_done_q & ~data_done_q;
    done_d    = data_done_q | capture_s;
  end

  // Fetch FSM with per-port bookkeeping and registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_q       <= {NumAll{1'b0}};
      gnt_done_q  <= {NumAll{1'b0}};
      data_done_q <= {NumAll{1'b0}};
      addr_q      <= {(NumAll*AddrWidth){1'b0}};
      buf_q       <= {(NumAll*DataWidth){1'b0}};
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid_i) begin
            state_q     <= FETCH;
            addr_q      <= addr_d;
            req_q       <= {NumAll{1'b1}};
            gnt_done_q  <= {NumAll{1'b0}};
            data_done_q <= {NumAll{1'b0}};
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        FETCH: begin
          req_q       <= req_q & ~tcdm_gnt_i;
          gnt_done_q  <= gnt_done_q | grant_s;
          data_done_q <= done_d;
          for (int p = 0; p < NumAll; p++) begin
            if (capture_s[p]) begin
              buf_q[p*DataWidth +: DataWidth] <= tcdm_rdata_i[p*DataWidth +: DataWidth];
            end
          end
          if (&done_d) begin
            state_q <= OUT;
            valid_q <= 1'b1;
          end
        end
        OUT: begin
          if (data_ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= {NumAll{1'b0}};
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready_o = ready_q;
  assign busy_o        = busy_q;
  assign data_valid_o  = valid_q;
  assign tcdm_req_o    = req_q;
  assign tcdm_addr_o   = addr_q;
  assign data_a_o      = buf_q[NumPorts*DataWidth-1:0];
  assign data_b_o      = buf_q[NumAll*DataWidth-1:NumPorts*DataWidth];

`ifdef GEMM_FETCH_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] fetch_q;
  logic        stall_s;
  logic        fetch_s;

  // Stall = fetching with at least one request left waiting this cycle.
  always_comb begin
    stall_s = (state_q == FETCH) && (|(req_q & ~tcdm_gnt_i));
    fetch_s = (state_q == OUT) && data_ready_i;
  end

  // Saturating performance counters; clear takes priority over increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= 32'd0;
      fetch_q <= 32'd0;
    end else if (perf_clr_i) begin
      stall_q <= 32'd0;
      fetch_q <= 32'd0;
    end else begin
      if (stall_s && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (fetch_s && (fetch_q != 32'hFFFF_FFFF)) begin
        fetch_q <= fetch_q + 32'd1;
      end
    end
  end

  assign perf_stall_o = stall_q;
  assign perf_fetch_o = fetch_q;
`endif

endmodule
